// File: rtl/worley_field_pipe.sv
// worley_field_pipe: moving feature points plus a 3-stage nearest-point Worley noise pipeline; define WORLEY_F2_EN for F2-F1 border shading
module worley_field_pipe #(
  parameter int NUM_PTS    = 4,
  parameter int COORD_W    = 10,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int DIST_SHIFT = 8,
  parameter int OUT_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic               pix_valid,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic               noise_valid,
  output logic [OUT_W-1:0]   noise,
  output logic [2:0]         cell_id,
  output logic               busy
);
  localparam int DW = 2*COORD_W+1;
  localparam int NW = COORD_W+2;
  typedef enum logic [1:0] {IDLE, UPD, COMMIT} state_t;
  state_t state, next_state;
  logic [2:0] idx, next_idx;
  logic [COORD_W-1:0] px_w[NUM_PTS], py_w[NUM_PTS], px_a[NUM_PTS], py_a[NUM_PTS];
  logic signed [3:0] vx[NUM_PTS], vy[NUM_PTS];
  logic [COORD_W:0] sx[NUM_PTS], sy[NUM_PTS];
  logic [COORD_W-1:0] dx[NUM_PTS], dy[NUM_PTS];
  logic [DW-1:0] d[NUM_PTS];
  logic v1, v2;
  logic [DW-1:0] best;
  logic [2:0] bi;
  logic [OUT_W-1:0] shade;
`ifdef WORLEY_F2_EN
  logic [DW-1:0] sec;
`endif
  function automatic logic [COORD_W-1:0] seed_p(input int bound, input int i);
    return COORD_W'((bound/(NUM_PTS+1))*(i+1));
  endfunction
  function automatic logic signed [3:0] seed_vx(input int i);
    return 4'((i%2 == 0) ? (i%3)+1 : -((i%3)+1));
  endfunction
  function automatic logic signed [3:0] seed_vy(input int i);
    return 4'((i%2 == 0) ? -(((i+1)%2)+1) : ((i+1)%2)+1);
  endfunction
  // {flip velocity, new position}: signed step clamped to 0..bound-1
  function automatic logic [COORD_W:0] step(input logic [COORD_W-1:0] p, input logic signed [3:0] v, input int bound);
    logic signed [NW-1:0] n;
    n = $signed({2'b00, p}) + $signed({{(NW-4){v[3]}}, v});
    return n < 0 ? {1'b1, COORD_W'(0)} : n > NW'(bound-1) ? {1'b1, COORD_W'(bound-1)} : {1'b0, n[COORD_W-1:0]};
  endfunction
  function automatic logic [OUT_W-1:0] sat(input logic [DW-1:0] v);
    logic [DW-1:0] s;
    s = v >> DIST_SHIFT;
    return s > DW'((1 << OUT_W) - 1) ? '1 : s[OUT_W-1:0];
  endfunction
  assign busy = state != IDLE;
  // update FSM state register
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= next_state;
      idx   <= next_idx;
    end
  // update FSM sequencing: one point per cycle, then a single commit cycle
  always_comb begin
    next_state = state == IDLE ? (frame_start ? UPD : IDLE) :
                 state == UPD  ? (idx == 3'(NUM_PTS-1) ? COMMIT : UPD) : IDLE;
    next_idx   = state == UPD ? idx + 3'd1 : '0;
  end
  // candidate bounced positions for every point
  always_comb
    for (int i = 0; i < NUM_PTS; i++) begin
      sx[i] = step(px_w[i], vx[i], H_ACTIVE);
      sy[i] = step(py_w[i], vy[i], V_ACTIVE);
    end
  // working set moves during UPD, active set follows on COMMIT
  always_ff @(posedge clk)
    if (!rst_n)
      for (int i = 0; i < NUM_PTS; i++) begin
        px_w[i] <= seed_p(H_ACTIVE, i);
        py_w[i] <= seed_p(V_ACTIVE, i);
        px_a[i] <= seed_p(H_ACTIVE, i);
        py_a[i] <= seed_p(V_ACTIVE, i);
        vx[i]   <= seed_vx(i);
        vy[i]   <= seed_vy(i);
      end
    else
      for (int i = 0; i < NUM_PTS; i++) begin
        if (state == UPD && idx == 3'(i)) begin
          px_w[i] <= sx[i][COORD_W-1:0];
          py_w[i] <= sy[i][COORD_W-1:0];
          if (sx[i][COORD_W]) vx[i] <= -vx[i];
          if (sy[i][COORD_W]) vy[i] <= -vy[i];
        end
        if (state == COMMIT) begin
          px_a[i] <= px_w[i];
          py_a[i] <= py_w[i];
        end
      end
  // S1 absolute deltas and S2 full-width squared distances
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_PTS; i++) begin
      dx[i] <= x >= px_a[i] ? x - px_a[i] : px_a[i] - x;
      dy[i] <= y >= py_a[i] ? y - py_a[i] : py_a[i] - y;
      d[i]  <= DW'(dx[i]) * DW'(dx[i]) + DW'(dy[i]) * DW'(dy[i]);
    end
  // S3 minimum search; strict compare keeps the lowest index on ties
  always_comb begin
    best = d[0];
    bi   = '0;
`ifdef WORLEY_F2_EN
    sec  = '1;
`endif
    for (int i = 1; i < NUM_PTS; i++) begin
`ifdef WORLEY_F2_EN
      sec = d[i] < best ? best : d[i] < sec ? d[i] : sec;
`endif
      if (d[i] < best) begin
        best = d[i];
        bi   = 3'(i);
      end
    end
`ifdef WORLEY_F2_EN
    shade = sat(sec - best);
`else
    shade = ~sat(best);
`endif
  end
  // valid chain and S3 output register; data holds across bubbles
  always_ff @(posedge clk)
    if (!rst_n) begin
      v1          <= 1'b0;
      v2          <= 1'b0;
      noise_valid <= 1'b0;
      noise       <= '0;
      cell_id     <= '0;
    end else begin
      v1          <= pix_valid;
      v2          <= v1;
      noise_valid <= v2;
      if (v2) begin
        noise   <= shade;
        cell_id <= bi;
      end
    end
endmodule

// File: tb/tb_worley_field_pipe.sv
// tb_worley_field_pipe: directed checks of latency, distance, bubbles, frame update, bounce, saturation, ties and reset
module tb_worley_field_pipe;
  logic clk = 0, rst_n = 0, frame_start = 0, pix_valid = 0;
  logic [9:0] x = 0, y = 0;
  logic noise_valid, busy, nv1, busy1;
  logic [7:0] noise, n1;
  logic [2:0] cell_id, c1;
  int checks = 0, errors = 0;
  worley_field_pipe dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_valid(pix_valid),
    .x(x), .y(y), .noise_valid(noise_valid), .noise(noise), .cell_id(cell_id), .busy(busy)
  );
  worley_field_pipe #(.NUM_PTS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_valid(pix_valid),
    .x(x), .y(y), .noise_valid(nv1), .noise(n1), .cell_id(c1), .busy(busy1)
  );
  always #5 clk = ~clk;
  task automatic run_pix(input logic [9:0] px, input logic [9:0] py, output logic v, output logic [7:0] n, output logic [2:0] c);
    @(negedge clk); pix_valid = 1; x = px; y = py;
    @(negedge clk); pix_valid = 0;
    repeat (2) @(negedge clk);
    v = noise_valid; n = noise; c = cell_id;
  endtask
  task automatic do_frame;
    @(negedge clk); frame_start = 1;
    @(negedge clk); frame_start = 0;
    repeat (6) @(negedge clk);
  endtask
  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(negedge clk);
    checks++; if (noise_valid !== 1'b0) begin errors++; $display("FAIL reset_nv got %b exp 0", noise_valid); end
    checks++; if (noise !== 8'h00) begin errors++; $display("FAIL reset_noise got %h exp 00", noise); end
    checks++; if (cell_id !== 3'd0) begin errors++; $display("FAIL reset_cell got %0d exp 0", cell_id); end
    checks++; if (busy !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b%b exp 00", busy, busy1); end
    rst_n = 1;
  endtask
  task automatic test_latency;
    @(negedge clk); pix_valid = 1; x = 128; y = 96;
    @(negedge clk); pix_valid = 0;
    @(negedge clk);
    checks++; if (noise_valid !== 1'b0) begin errors++; $display("FAIL lat_early got %b exp 0", noise_valid); end
    @(negedge clk);
    checks++; if (noise_valid !== 1'b1) begin errors++; $display("FAIL lat_valid got %b exp 1", noise_valid); end
    checks++; if (noise !== 8'hFF) begin errors++; $display("FAIL lat_noise got %h exp ff", noise); end
    checks++; if (cell_id !== 3'd0) begin errors++; $display("FAIL lat_cell got %0d exp 0", cell_id); end
    @(negedge clk);
    checks++; if (noise_valid !== 1'b0) begin errors++; $display("FAIL lat_pulse got %b exp 0", noise_valid); end
  endtask
  task automatic test_distance;
    logic v; logic [7:0] n; logic [2:0] c;
    run_pix(0, 0, v, n, c);
    checks++; if (n !== 8'h9B || v !== 1'b1) begin errors++; $display("FAIL dist_00 got %h/%b exp 9b/1", n, v); end
    checks++; if (c !== 3'd0) begin errors++; $display("FAIL dist_00_cell got %0d exp 0", c); end
    run_pix(639, 479, v, n, c);
    checks++; if (n !== 8'h9D) begin errors++; $display("FAIL dist_corner got %h exp 9d", n); end
    checks++; if (c !== 3'd3) begin errors++; $display("FAIL dist_corner_cell got %0d exp 3", c); end
  endtask
  task automatic test_bubble;
    @(negedge clk); pix_valid = 1; x = 0; y = 0;
    @(negedge clk); pix_valid = 0;
    @(negedge clk); pix_valid = 1; x = 128; y = 96;
    @(negedge clk); pix_valid = 0;
    checks++; if (noise_valid !== 1'b1 || noise !== 8'h9B) begin errors++; $display("FAIL bub_a got %b/%h exp 1/9b", noise_valid, noise); end
    @(negedge clk);
    checks++; if (noise_valid !== 1'b0 || noise !== 8'h9B) begin errors++; $display("FAIL bub_hole got %b/%h exp 0/9b", noise_valid, noise); end
    @(negedge clk);
    checks++; if (noise_valid !== 1'b1 || noise !== 8'hFF) begin errors++; $display("FAIL bub_b got %b/%h exp 1/ff", noise_valid, noise); end
  endtask
  task automatic test_saturation;
    logic v; logic [7:0] n; logic [2:0] c;
    run_pix(639, 479, v, n, c);
    checks++; if (nv1 !== 1'b1 || n1 !== 8'h00) begin errors++; $display("FAIL sat_one got %b/%h exp 1/00", nv1, n1); end
    checks++; if (c1 !== 3'd0) begin errors++; $display("FAIL sat_one_cell got %0d exp 0", c1); end
  endtask
  task automatic test_tie;
    logic v; logic [7:0] n; logic [2:0] c;
    run_pix(192, 144, v, n, c);
    checks++; if (c !== 3'd0) begin errors++; $display("FAIL tie_cell got %0d exp 0", c); end
    checks++; if (n !== 8'hE6) begin errors++; $display("FAIL tie_noise got %h exp e6", n); end
  endtask
  task automatic test_frame;
    logic v; logic [7:0] n; logic [2:0] c;
    int cnt;
    cnt = 0;
    @(negedge clk); frame_start = 1;
    @(negedge clk); frame_start = 0;
    for (int k = 0; k < 20; k++) begin
      if (busy) cnt++;
      frame_start = (k == 1);
      @(negedge clk);
    end
    checks++; if (cnt !== 5) begin errors++; $display("FAIL frame_busy got %0d exp 5", cnt); end
    run_pix(129, 94, v, n, c);
    checks++; if (n !== 8'hFF || c !== 3'd0) begin errors++; $display("FAIL frame_pos got %h/%0d exp ff/0", n, c); end
  endtask
  task automatic test_bounce;
    logic v; logic [7:0] n; logic [2:0] c;
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1;
    repeat (48) do_frame;
    run_pix(176, 0, v, n, c);
    checks++; if (n !== 8'hFF || c !== 3'd0) begin errors++; $display("FAIL bounce_48 got %h/%0d exp ff/0", n, c); end
    do_frame;
    run_pix(177, 0, v, n, c);
    checks++; if (n !== 8'hFF || c !== 3'd0) begin errors++; $display("FAIL bounce_49 got %h/%0d exp ff/0", n, c); end
    do_frame;
    run_pix(178, 2, v, n, c);
    checks++; if (n !== 8'hFF || c !== 3'd0) begin errors++; $display("FAIL bounce_50 got %h/%0d exp ff/0", n, c); end
  endtask
  task automatic test_reset_mid;
    logic v; logic [7:0] n; logic [2:0] c;
    @(negedge clk); frame_start = 1; pix_valid = 1; x = 0; y = 0;
    @(negedge clk); frame_start = 0; pix_valid = 0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_pre got %b exp 1", busy); end
    rst_n = 0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || noise_valid !== 1'b0) begin errors++; $display("FAIL mid_abort got %b/%b exp 0/0", busy, noise_valid); end
    checks++; if (noise !== 8'h00) begin errors++; $display("FAIL mid_noise got %h exp 00", noise); end
    rst_n = 1;
    run_pix(128, 96, v, n, c);
    checks++; if (n !== 8'hFF || c !== 3'd0 || v !== 1'b1) begin errors++; $display("FAIL mid_seed got %h/%0d/%b exp ff/0/1", n, c, v); end
  endtask
  initial begin
    test_reset;
    test_latency;
    test_distance;
    test_bubble;
    test_saturation;
    test_tie;
    test_frame;
    test_bounce;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
